// File: rtl/axi_sync_frame_gate_pkg.sv
// Shared defaults for the sync-word frame gate slice.
package axi_sync_frame_gate_pkg;

    localparam int unsigned SFG_DWIDTH_DEF   = 64;
    localparam int unsigned SFG_UWIDTH_DEF   = 1;
    localparam int unsigned SFG_LWIDTH_DEF   = 16;
    localparam int unsigned SFG_MAX_MISS_DEF = 3;
    localparam int unsigned SFG_FCNT_W       = 16;

endpackage

// File: rtl/axi_sync_frame_gate_stage.sv
// Single AXI-stream register slice carrying {user, data, first, last}.
module axi_pipeline_stage #(
    parameter int unsigned DWIDTH = 64,
    parameter int unsigned UWIDTH = 1
) (
    input  logic              clk,
    input  logic              aresetn,
    input  logic              load,
    input  logic [DWIDTH-1:0] in_data,
    input  logic [UWIDTH-1:0] in_user,
    input  logic              in_first,
    input  logic              in_last,
    input  logic              out_ready,
    output logic              advance_c,
    output logic              out_valid,
    output logic [DWIDTH-1:0] out_data,
    output logic [UWIDTH-1:0] out_user,
    output logic              out_first,
    output logic              out_last
);

    assign advance_c = out_ready | ~out_valid;

    // Word is held until consumed; payload fields only change on a load.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_user  <= '0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
        end else if (advance_c) begin
            out_valid <= load;
            if (load) begin
                out_data  <= in_data;
                out_user  <= in_user;
                out_first <= in_first;
                out_last  <= in_last;
            end
        end
    end

endmodule

// File: rtl/axi_sync_frame_gate.sv
// Flywheel frame synchroniser: hunts for the sync word, forwards payload with first/last tags.
module axi_sync_frame_gate
    import axi_sync_frame_gate_pkg::*;
#(
    parameter int unsigned DWIDTH   = SFG_DWIDTH_DEF,
    parameter int unsigned UWIDTH   = SFG_UWIDTH_DEF,
    parameter int unsigned LWIDTH   = SFG_LWIDTH_DEF,
    parameter int unsigned MAX_MISS = SFG_MAX_MISS_DEF
) (
    input  logic                  clk,
    input  logic                  aresetn,
    input  logic [LWIDTH-1:0]     frame_len,
    output logic                  s_axi_ready,
    input  logic                  s_axi_valid,
    input  logic [DWIDTH-1:0]     s_axi_data,
    input  logic [UWIDTH-1:0]     s_axi_user,
    input  logic                  s_axi_equal,
    input  logic                  m_axi_ready,
    output logic                  m_axi_valid,
    output logic [DWIDTH-1:0]     m_axi_data,
    output logic [UWIDTH-1:0]     m_axi_user,
    output logic                  m_axi_first,
    output logic                  m_axi_last,
    output logic                  locked,
    output logic                  sync_lost,
    output logic [SFG_FCNT_W-1:0] frame_count
);

    localparam int unsigned MISS_W = (MAX_MISS < 2) ? 1 : $clog2(MAX_MISS + 1);

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_CHECK   = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [LWIDTH-1:0]     cnt_q, cnt_d;
    logic [LWIDTH-1:0]     len_q, len_d;
    logic [MISS_W-1:0]     miss_q, miss_d;
    logic [SFG_FCNT_W-1:0] fcnt_q, fcnt_d;
    logic                  locked_q, locked_d;
    logic                  lost_q, lost_d;

    logic                  advance_c;
    logic                  accept_c;
    logic                  load_c;
    logic                  first_c;
    logic                  last_c;
    logic [LWIDTH-1:0]     len_new_c;

    assign s_axi_ready = advance_c;
    assign accept_c    = s_axi_valid & advance_c;
    assign len_new_c   = (frame_len == '0) ? LWIDTH'(1) : frame_len;

    assign locked      = locked_q;
    assign sync_lost   = lost_q;
    assign frame_count = fcnt_q;

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state_q  <= ST_HUNT;
            cnt_q    <= '0;
            len_q    <= LWIDTH'(1);
            miss_q   <= '0;
            fcnt_q   <= '0;
            locked_q <= 1'b0;
            lost_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            len_q    <= len_d;
            miss_q   <= miss_d;
            fcnt_q   <= fcnt_d;
            locked_q <= locked_d;
            lost_q   <= lost_d;
        end
    end

    // Next-state and payload tagging; nothing moves unless a word is accepted.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        miss_d  = miss_q;
        fcnt_d  = fcnt_q;
        lost_d  = 1'b0;
        load_c  = 1'b0;
        first_c = 1'b0;
        last_c  = 1'b0;

        if (accept_c) begin
            case (state_q)
                ST_HUNT: begin
                    if (s_axi_equal) begin
                        len_d   = len_new_c;
                        cnt_d   = '0;
                        miss_d  = '0;
                        state_d = ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    load_c  = 1'b1;
                    first_c = (cnt_q == '0);
                    last_c  = (cnt_q == (len_q - LWIDTH'(1)));
                    if (last_c) begin
                        cnt_d   = '0;
                        fcnt_d  = fcnt_q + SFG_FCNT_W'(1);
                        state_d = ST_CHECK;
                    end else begin
                        cnt_d = cnt_q + LWIDTH'(1);
                    end
                end
                ST_CHECK: begin
                    if (s_axi_equal) begin
                        miss_d  = '0;
                        len_d   = len_new_c;
                        cnt_d   = '0;
                        state_d = ST_PAYLOAD;
                    end else if ((32'(miss_q) + 32'd1) < 32'(MAX_MISS)) begin
                        miss_d  = miss_q + MISS_W'(1);
                        len_d   = len_new_c;
                        cnt_d   = '0;
                        state_d = ST_PAYLOAD;
                    end else begin
                        state_d = ST_HUNT;
                        lost_d  = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_HUNT;
                end
            endcase
        end
    end

    assign locked_d = (state_d != ST_HUNT);

    axi_pipeline_stage #(
        .DWIDTH (DWIDTH),
        .UWIDTH (UWIDTH)
    ) u_out_stage (
        .clk       (clk),
        .aresetn   (aresetn),
        .load      (load_c),
        .in_data   (s_axi_data),
        .in_user   (s_axi_user),
        .in_first  (first_c),
        .in_last   (last_c),
        .out_ready (m_axi_ready),
        .advance_c (advance_c),
        .out_valid (m_axi_valid),
        .out_data  (m_axi_data),
        .out_user  (m_axi_user),
        .out_first (m_axi_first),
        .out_last  (m_axi_last)
    );

endmodule

// File: tb/tb_axi_sync_frame_gate.sv
// Directed bench for axi_sync_frame_gate with a transaction-level framing model.
module tb_axi_sync_frame_gate;

    localparam int unsigned DW = 64;
    localparam int unsigned MAXM = 3;
    localparam logic [63:0] SYNC = 64'hA5A5_5A5A_F00D_CAFE;

    logic        clk = 1'b0;
    logic        aresetn = 1'b0;
    logic [15:0] frame_len = 16'd4;
    logic        s_axi_ready;
    logic        s_axi_valid = 1'b0;
    logic [63:0] s_axi_data = '0;
    logic [0:0]  s_axi_user = '0;
    logic        s_axi_equal = 1'b0;
    logic        m_axi_ready = 1'b1;
    logic        m_axi_valid;
    logic [63:0] m_axi_data;
    logic [0:0]  m_axi_user;
    logic        m_axi_first;
    logic        m_axi_last;
    logic        locked;
    logic        sync_lost;
    logic [15:0] frame_count;

    axi_sync_frame_gate #(
        .DWIDTH(DW), .UWIDTH(1), .LWIDTH(16), .MAX_MISS(MAXM)
    ) dut (
        .clk(clk), .aresetn(aresetn), .frame_len(frame_len),
        .s_axi_ready(s_axi_ready), .s_axi_valid(s_axi_valid), .s_axi_data(s_axi_data),
        .s_axi_user(s_axi_user), .s_axi_equal(s_axi_equal),
        .m_axi_ready(m_axi_ready), .m_axi_valid(m_axi_valid), .m_axi_data(m_axi_data),
        .m_axi_user(m_axi_user), .m_axi_first(m_axi_first), .m_axi_last(m_axi_last),
        .locked(locked), .sync_lost(sync_lost), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: framing rules applied per accepted word, expected payload kept in a queue.
    typedef struct packed {
        logic [63:0] d;
        logic        u;
        logic        f;
        logic        l;
    } exp_t;

    exp_t        q[$];
    bit          m_locked = 0;
    bit          m_expect_sync = 0;
    int          m_pos = 0;
    int          m_len = 1;
    int          m_miss = 0;
    int          m_fc = 0;
    bit          exp_lost = 0;

    logic [63:0] log_d[$];
    bit          log_f[$];
    bit          log_l[$];
    int          lost_cnt = 0;
    bit          bp = 0;

    task automatic model_word(input logic [63:0] d, input logic u, input logic eq, input int fl);
        exp_t e;
        if (!m_locked) begin
            if (eq) begin
                m_locked = 1; m_expect_sync = 0; m_pos = 0; m_miss = 0;
                m_len = (fl == 0) ? 1 : fl;
            end
        end else if (m_expect_sync) begin
            m_miss = eq ? 0 : m_miss + 1;
            if (m_miss == MAXM) begin
                m_locked = 0; exp_lost = 1;
            end else begin
                m_expect_sync = 0; m_pos = 0;
                m_len = (fl == 0) ? 1 : fl;
            end
        end else begin
            e.d = d; e.u = u; e.f = (m_pos == 0); e.l = (m_pos == m_len - 1);
            q.push_back(e);
            m_pos++;
            if (m_pos == m_len) begin
                m_fc++; m_expect_sync = 1;
            end
        end
    endtask

    // Compare output handshakes against the model, then feed the model the accepted input.
    always @(posedge clk) begin
        exp_t e;
        if (!aresetn) begin
            q.delete();
            m_locked = 0; m_expect_sync = 0; m_pos = 0; m_miss = 0; m_fc = 0; exp_lost = 0;
        end else begin
            exp_lost = 0;
            if (m_axi_valid && m_axi_ready) begin
                if (q.size() == 0) begin
                    n_checks++; n_err++;
                    $display("FAIL unexpected_output: got %0h expected none", m_axi_data);
                end else begin
                    e = q.pop_front();
                    chk("out_data", m_axi_data, e.d);
                    chk("out_user", 64'(m_axi_user), 64'(e.u));
                    chk("out_first", 64'(m_axi_first), 64'(e.f));
                    chk("out_last", 64'(m_axi_last), 64'(e.l));
                    log_d.push_back(m_axi_data);
                    log_f.push_back(m_axi_first);
                    log_l.push_back(m_axi_last);
                end
            end
            if (s_axi_valid && s_axi_ready)
                model_word(s_axi_data, s_axi_user[0], s_axi_equal, int'(frame_len));
        end
    end

    // Per-cycle status checks, sampled away from the active edge.
    always @(negedge clk) begin
        chk("locked", 64'(locked), 64'(m_locked));
        chk("sync_lost", 64'(sync_lost), 64'(exp_lost));
        chk("frame_count", 64'(frame_count), 64'(m_fc & 16'hFFFF));
        chk("m_valid", 64'(m_axi_valid), 64'(q.size() != 0));
        if (sync_lost) lost_cnt++;
    end

    always @(negedge clk) m_axi_ready = bp ? ($urandom_range(0, 9) < 3) : 1'b1;

    task automatic send(input logic [63:0] d, input logic eq);
        bit done = 0;
        int guard = 0;
        while (!done) begin
            @(negedge clk);
            s_axi_valid = 1'b1; s_axi_data = d; s_axi_user = d[0]; s_axi_equal = eq;
            #1;
            if (s_axi_ready) done = 1;
            @(posedge clk);
            guard++;
            if (!done && guard > 200) begin
                n_checks++; n_err++;
                $display("FAIL send_timeout: got stalled expected accept of %0h", d);
                done = 1;
            end
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        s_axi_valid = 1'b0; s_axi_equal = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_log();
        log_d.delete(); log_f.delete(); log_l.delete();
    endtask

    task automatic chk_log(input int i, input logic [63:0] d, input bit f, input bit l);
        if (i >= log_d.size()) begin
            n_checks++; n_err++;
            $display("FAIL log_missing: got %0d words expected index %0d", log_d.size(), i);
        end else begin
            chk("log_data", log_d[i], d);
            chk("log_first", 64'(log_f[i]), 64'(f));
            chk("log_last", 64'(log_l[i]), 64'(l));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_valid", 64'(m_axi_valid), 64'd0);
        chk("rst_data", m_axi_data, 64'd0);
        chk("rst_locked", 64'(locked), 64'd0);
        chk("rst_fcnt", 64'(frame_count), 64'd0);
        aresetn = 1'b1;

        // Lock and two frames of 4
        frame_len = 16'd4;
        clear_log();
        send(SYNC, 1);
        for (int i = 1; i <= 4; i++) send(64'h10 + 64'(i), 0);
        send(SYNC, 1);
        for (int i = 5; i <= 8; i++) send(64'h10 + 64'(i), 0);
        idle(3);
        chk("t1_words", 64'(log_d.size()), 64'd8);
        chk_log(0, 64'h11, 1, 0);
        chk_log(3, 64'h14, 0, 1);
        chk_log(4, 64'h15, 1, 0);
        chk_log(7, 64'h18, 0, 1);
        chk("t1_fcnt", 64'(frame_count), 64'd2);
        chk("t1_locked", 64'(locked), 64'd1);

        // Flywheel across two misses, a good sync clears the miss count
        frame_len = 16'd2;
        clear_log();
        lost_cnt = 0;
        for (int f = 0; f < 5; f++) begin
            send(SYNC ^ 64'h1, (f == 2));
            send(64'h20 + 64'(2 * f), 0);
            send(64'h21 + 64'(2 * f), 0);
        end
        idle(2);
        chk("t2_lost", 64'(lost_cnt), 64'd0);
        chk("t2_words", 64'(log_d.size()), 64'd10);
        chk_log(8, 64'h28, 1, 0);
        chk_log(9, 64'h29, 0, 1);
        chk("t2_fcnt", 64'(frame_count), 64'd7);

        // Third consecutive miss drops lock; following payload discarded
        send(SYNC ^ 64'h2, 0);
        send(64'h30, 0);
        send(64'h31, 0);
        idle(2);
        chk("t3_lost", 64'(lost_cnt), 64'd1);
        chk("t3_locked", 64'(locked), 64'd0);
        chk("t3_words", 64'(log_d.size()), 64'd10);

        // Hunt discard then a short frame
        clear_log();
        for (int i = 0; i < 5; i++) send(64'h40 + 64'(i), 0);
        send(SYNC, 1);
        send(64'h1, 0);
        send(64'h2, 0);
        idle(2);
        chk("t4_words", 64'(log_d.size()), 64'd2);
        chk_log(0, 64'h1, 1, 0);
        chk_log(1, 64'h2, 0, 1);
        chk("t4_fcnt", 64'(frame_count), 64'd8);

        // frame_len 0 behaves as 1
        frame_len = 16'd0;
        clear_log();
        for (int i = 0; i < 3; i++) begin
            send(SYNC, 1);
            send(64'h50 + 64'(i), 0);
        end
        idle(2);
        chk_log(0, 64'h50, 1, 1);
        chk_log(2, 64'h52, 1, 1);
        chk("t5_fcnt", 64'(frame_count), 64'd11);

        // Random downstream backpressure
        frame_len = 16'd3;
        clear_log();
        bp = 1;
        for (int f = 0; f < 4; f++) begin
            send(SYNC, (f != 1));
            for (int i = 0; i < 3; i++) send(64'h60 + 64'(4 * f + i), 0);
        end
        idle(1);
        bp = 0;
        repeat (5) @(negedge clk);
        chk("t6_words", 64'(log_d.size()), 64'd12);
        chk("t6_drained", 64'(q.size()), 64'd0);
        chk_log(11, 64'h6E, 0, 1);
        chk("t6_fcnt", 64'(frame_count), 64'd15);

        // Reset mid-frame abandons the frame
        frame_len = 16'd4;
        send(SYNC, 1);
        send(64'h70, 0);
        send(64'h71, 0);
        @(negedge clk);
        s_axi_valid = 1'b0;
        aresetn = 1'b0;
        @(negedge clk);
        chk("mr_valid", 64'(m_axi_valid), 64'd0);
        chk("mr_first", 64'(m_axi_first), 64'd0);
        chk("mr_last", 64'(m_axi_last), 64'd0);
        chk("mr_data", m_axi_data, 64'd0);
        chk("mr_locked", 64'(locked), 64'd0);
        chk("mr_fcnt", 64'(frame_count), 64'd0);
        aresetn = 1'b1;
        clear_log();
        send(64'h72, 0);
        send(SYNC, 1);
        for (int i = 0; i < 4; i++) send(64'h80 + 64'(i), 0);
        idle(2);
        chk("t7_words", 64'(log_d.size()), 64'd4);
        chk_log(0, 64'h80, 1, 0);
        chk_log(3, 64'h83, 0, 1);
        chk("t7_fcnt", 64'(frame_count), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
